head_gbus_wr_arb: RTL

- Shares one head-level global-bus write port between CORE_NUM cores.
- Each core's out_gbus write stream (addr/wen/wdata) enters its own small FIFO.
- A round-robin arbiter drains the FIFOs into one registered output stage with a ready/valid handshake toward the gbus fabric.
- Sits between the core_top instances of one head and the head's global-bus interconnect.

---
 rtl/head_gbus_pkg.sv | 17 +
 rtl/gbus_wr_fifo.sv | 67 ++++++
 rtl/head_gbus_wr_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/head_gbus_pkg.sv
// Shared global-bus definitions for the head-level write arbiter.
package head_gbus_pkg;

  localparam int unsigned HEAD_SRAM_BIAS_WIDTH = 2;
  localparam int unsigned BUS_CORE_ADDR_WIDTH  = 4;
  localparam int unsigned BUS_CMEM_ADDR_WIDTH  = 13;
  localparam int unsigned GBUS_ADDR_WIDTH      =
      HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH + BUS_CMEM_ADDR_WIDTH;
  localparam int unsigned GBUS_DATA_WIDTH      = 32;

  // One global-bus write beat as carried through the per-core FIFOs.
  typedef struct packed {
    logic [GBUS_ADDR_WIDTH-1:0] addr;
    logic [GBUS_DATA_WIDTH-1:0] data;
  } gbus_wr_t;

endpackage

// File: rtl/gbus_wr_fifo.sv
// Small synchronous FIFO buffering one core's global-bus write stream.
// DEPTH must be a power of two so the pointers wrap naturally.
module gbus_wr_fifo #(
  parameter int unsigned WIDTH = 51,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  import head_gbus_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; payload needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/head_gbus_wr_arb.sv
// Head-level global-bus write arbiter: per-core FIFOs drained round-robin into
// a single registered ready/valid output stage.
module head_gbus_wr_arb #(
  parameter int unsigned CORE_NUM        = 4,
  parameter int unsigned GBUS_ADDR_WIDTH = head_gbus_pkg::GBUS_ADDR_WIDTH,
  parameter int unsigned GBUS_DATA_WIDTH = head_gbus_pkg::GBUS_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CORE_NUM-1:0]                 core_gbus_wen,
  input  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] core_gbus_addr,
  input  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] core_gbus_wdata,
  output logic [CORE_NUM-1:0]                 core_fifo_full,
  output logic                                out_gbus_wen,
  output logic [GBUS_ADDR_WIDTH-1:0]          out_gbus_addr,
  output logic [GBUS_DATA_WIDTH-1:0]          out_gbus_wdata,
  input  logic                                out_gbus_ready,
  output logic [$clog2(CORE_NUM)-1:0]         out_gbus_src,
  output logic [CORE_NUM-1:0]                 ovf_err,
  input  logic                                ovf_clear,
  output logic                                idle
);

  import head_gbus_pkg::*;

  localparam int unsigned SRC_W  = $clog2(CORE_NUM);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORD_W = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;

  logic [CORE_NUM-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_set;
  logic [WORD_W-1:0]   fifo_head  [CORE_NUM];
  logic [CNT_W-1:0]    fifo_count [CORE_NUM];

  logic                       load_ok;
  logic                       grant_vld;
  logic [SRC_W-1:0]           grant_idx;
  logic                       all_empty;

  logic                       out_wen_q;
  logic [GBUS_ADDR_WIDTH-1:0] out_addr_q;
  logic [GBUS_DATA_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]           out_src_q;
  logic [SRC_W-1:0]           ptr_q;
  logic [CORE_NUM-1:0]        ovf_q;

  // Output register may accept a new word when empty or draining this cycle.
  assign load_ok = !out_wen_q || out_gbus_ready;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_fifo
    gbus_wr_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .wdata ({core_gbus_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
               core_gbus_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]}),
      .rdata (fifo_head[i]),
      .count (fifo_count[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  // Push qualification and overflow detection; a full FIFO popped this cycle still accepts.
  always_comb begin
    fifo_push = '0;
    ovf_set   = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      fifo_push[i] = core_gbus_wen[i] && (!fifo_full[i] || fifo_pop[i]);
      ovf_set[i]   = core_gbus_wen[i] && fifo_full[i] && !fifo_pop[i];
    end
  end

  // Round-robin search starting one past the last granted core.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= CORE_NUM; k++) begin
      cand = (32'(ptr_q) + k) % CORE_NUM;
      if (!grant_vld && !fifo_empty[SRC_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end

  // Pop only the granted FIFO, and only when the output stage can take its head.
  always_comb begin
    fifo_pop = '0;
    if (load_ok && grant_vld) begin
      fifo_pop[grant_idx] = 1'b1;
    end
  end

  // Registered output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wen_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
      ptr_q      <= SRC_W'(CORE_NUM - 1);
    end else if (load_ok) begin
      if (grant_vld) begin
        out_wen_q                <= 1'b1;
        {out_addr_q, out_data_q} <= fifo_head[grant_idx];
        out_src_q                <= grant_idx;
        ptr_q                    <= grant_idx;
      end else begin
        out_wen_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flags; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clear ? '0 : ovf_q) | ovf_set;
    end
  end

  // Idle when every FIFO and the output stage are empty.
  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (fifo_count[i] != '0) all_empty = 1'b0;
    end
  end

  assign idle           = all_empty && !out_wen_q;
  assign core_fifo_full = fifo_full;
  assign ovf_err        = ovf_q;
  assign out_gbus_wen   = out_wen_q;
  assign out_gbus_addr  = out_addr_q;
  assign out_gbus_wdata = out_data_q;
  assign out_gbus_src   = out_src_q;

endmodule
